rr_bus_arbiter: RTL
===================

Name: rr_bus_arbiter

Overview:
- Round-robin arbiter that shares the common memory bus (address/read/write/mask/value/ready/fault) among NUM_MASTERS bus masters, e.g. CPU instruction port, CPU data port and a future DMA engine.
- Sits between the masters and the address-decode/peripheral fabric.
- Locks the grant for a whole transaction.
- Adds a bus watchdog that terminates hung transactions with a fault.

Parameters:
- NUM_MASTERS, 3, number of requesting masters (2..8).
- TIMEOUT, 255, max extra BUSY cycles waiting for ready_in before forced fault; 0 disables the watchdog.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- m_address_in  input  NUM_MASTERS*32  per-master address, master i at [32*i+:32].
- m_read_in  input  NUM_MASTERS  per-master read request.
- m_write_in  input  NUM_MASTERS  per-master write request.
- m_write_mask_in  input  NUM_MASTERS*4  per-master byte mask.
- m_write_value_in  input  NUM_MASTERS*32  per-master write data.
- m_read_value_out  output  NUM_MASTERS*32  read data, nonzero only for the completing master.
- m_ready_out  output  NUM_MASTERS  completion strobe, one-hot or zero.
- m_fault_out  output  NUM_MASTERS  fault strobe, subset of m_ready_out.
- address_out  output  32  common bus address.
- read_out  output  1  common bus read.
- write_out  output  1  common bus write.
- write_mask_out  output  4  common bus mask.
- write_value_out  output  32  common bus write data.
- read_value_in  input  32  common bus read data.
- ready_in  input  1  slave ready, ORed from the decode fabric.
- fault_in  input  1  decode fault.
- grant_out  output  NUM_MASTERS  registered one-hot current grant, debug.
- timeout_out  output  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Master rules:
  - A request is read|write, held stable until that master's m_ready_out.
  - Read and write both high is treated as write.
- State machine: IDLE, BUSY.
- Reset:
  - state=IDLE, ptr=0, grant=0, wd_cnt=0.
  - All outputs 0 from the cycle after reset is sampled.
  - Any in-flight transaction is dropped with no ready to its master.
- IDLE:
  - Bus outputs all 0; m_ready_out = m_fault_out = 0.
  - If any request: winner = first requesting index scanning ptr, ptr+1, …, wrapping modulo NUM_MASTERS.
  - grant <= onehot(winner), wd_cnt <= 0, state <= BUSY.
  - This arbitration cycle is not visible on the bus (1-cycle grant latency).
- BUSY:
  - Bus outputs combinationally mux the granted master's fields.
  - write_mask_out is forced 0 when write_out=0.
  - done = ready_in | fault_in | wd_fire, where wd_fire = (TIMEOUT!=0) && (wd_cnt==TIMEOUT) && !ready_in && !fault_in.
  - On done, for the granted master g, in the same cycle:
    - m_ready_out[g]=1
    - m_fault_out[g] = fault_in | wd_fire
    - m_read_value_out[g] = wd_fire ? 0 : read_value_in
  - On done, next-state updates:
    - state <= IDLE, ptr <= (g+1) mod NUM_MASTERS, grant <= 0.
    - timeout_out=1 for one cycle iff wd_fire.
  - Not done: wd_cnt <= wd_cnt+1, saturating at TIMEOUT.
- Watchdog bounds: a transaction occupies at most TIMEOUT+1 BUSY cycles. With TIMEOUT=0, BUSY waits forever.
- Abandon: granted master drops both read and write while BUSY and not done → state <= IDLE, ptr advances, no ready/fault issued.
- Non-granted masters always see ready=fault=0 and read_value=0, so their read data can be ORed freely.
- Throughput:
  - Minimum 2 cycles per transaction (arbitrate + bus).
  - A single continuous requester gets back-to-back transactions every 2 cycles.
  - With N masters all requesting, each is served once per N transactions; no starvation.
- Simultaneous ready_in and fault_in: fault wins (fault=1, ready=1).
- Request arriving on the done cycle is arbitrated in the following IDLE cycle.
- ptr width = clog2(NUM_MASTERS); wrap by explicit compare, not power-of-two masking.

Decomposition:
- Package icicle_bus_pkg:
  - BUS_ADDR_W=32, BUS_DATA_W=32, BUS_MASK_W=4.
  - arb_state_t enum {ARB_IDLE, ARB_BUSY}.
- Sub-module rr_pick: combinational rotate-priority encoder. Inputs req vector and ptr; outputs onehot winner and index.
- Everything else, including the watchdog counter, lives in rr_bus_arbiter.

Test Plan:
- Single master 1 reads 0x00010004, slave ready_in same cycle with 0x5 → grant_out=010 one cycle after request; m_ready_out[1]=1 and m_read_value_out[1]=0x5 in next cycle; other masters see 0.
- All 3 masters request continuously after reset → grant order 0,1,2,0,1,2; one completion every 2 cycles.
- Master 2 write, mask 4'b0011, value 0xDEADBEEF → write_mask_out=0011, write_value_out=DEADBEEF during BUSY; read-only master 0 drives write_mask_out=0.
- TIMEOUT=4, ready_in held 0 → 5 BUSY cycles, then m_ready_out=m_fault_out=1, read_value 0, timeout_out one-cycle pulse, ptr advances.
- fault_in=1 on first BUSY cycle (unmapped 0x00040000) → immediate ready+fault to that master, no timeout_out.
- reset asserted mid-BUSY, and separately granted master dropping its request mid-BUSY → no m_ready_out; arbiter IDLE next cycle; on reset ptr=0 and master 0 wins if all request.

Source files
------------

// File: rtl/icicle_bus_pkg.sv
// Shared bus widths and arbiter state encoding
// for the icicle memory bus fabric.
package icicle_bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_MASK_W = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first request found
// scanning from ptr upwards, wrapping at N.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_in,
  input  logic [PW-1:0] ptr_in,
  output logic [N-1:0]  onehot_out,
  output logic [PW-1:0] index_out
);

  // Scan from the farthest slot back to ptr so the
  // closest requester to ptr is the last (winning) write.
  always_comb begin
    int j;
    onehot_out = '0;
    index_out  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_in) + k;
      if (j >= N) j = j - N;
      if (req_in[j]) begin
        onehot_out    = '0;
        onehot_out[j] = 1'b1;
        index_out     = PW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for the shared memory bus,
// locking grant per transaction with a hang watchdog.
module rr_bus_arbiter
  import icicle_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int TIMEOUT     = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS*BUS_ADDR_W-1:0] m_address_in,
  input  logic [NUM_MASTERS-1:0]            m_read_in,
  input  logic [NUM_MASTERS-1:0]            m_write_in,
  input  logic [NUM_MASTERS*BUS_MASK_W-1:0] m_write_mask_in,
  input  logic [NUM_MASTERS*BUS_DATA_W-1:0] m_write_value_in,
  output logic [NUM_MASTERS*BUS_DATA_W-1:0] m_read_value_out,
  output logic [NUM_MASTERS-1:0]            m_ready_out,
  output logic [NUM_MASTERS-1:0]            m_fault_out,
  output logic [BUS_ADDR_W-1:0]             address_out,
  output logic                              read_out,
  output logic                              write_out,
  output logic [BUS_MASK_W-1:0]             write_mask_out,
  output logic [BUS_DATA_W-1:0]             write_value_out,
  input  logic [BUS_DATA_W-1:0]             read_value_in,
  input  logic                              ready_in,
  input  logic                              fault_in,
  output logic [NUM_MASTERS-1:0]            grant_out,
  output logic                              timeout_out
);

  localparam int N  = NUM_MASTERS;
  localparam int PW = $clog2(N);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_V = TW'(TIMEOUT);
  localparam logic WD_EN = (TIMEOUT != 0);

  arb_state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gidx_q, gidx_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [TW-1:0] wd_cnt_q, wd_cnt_d;
  logic          timeout_q, timeout_d;

  logic [N-1:0]  req;
  logic [N-1:0]  pick_oh;
  logic [PW-1:0] pick_idx;
  logic [PW-1:0] ptr_next;
  logic          busy;
  logic          g_rd;
  logic          g_wr;
  logic          wd_fire;
  logic          done;

  assign req         = m_read_in | m_write_in;
  assign grant_out   = grant_q;
  assign timeout_out = timeout_q;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req_in     (req),
    .ptr_in     (ptr_q),
    .onehot_out (pick_oh),
    .index_out  (pick_idx)
  );

  // Mux the granted master onto the bus and route completion back.
  always_comb begin
    int gi;
    gi               = int'(gidx_q);
    busy             = (state_q == ARB_BUSY);
    g_rd             = m_read_in[gi];
    g_wr             = m_write_in[gi];
    wd_fire          = WD_EN && busy && (wd_cnt_q == TO_V)
                       && !ready_in && !fault_in;
    done             = busy && (ready_in || fault_in || wd_fire);
    address_out      = '0;
    read_out         = 1'b0;
    write_out        = 1'b0;
    write_mask_out   = '0;
    write_value_out  = '0;
    m_ready_out      = '0;
    m_fault_out      = '0;
    m_read_value_out = '0;
    if (busy) begin
      address_out     = m_address_in[gi*BUS_ADDR_W +: BUS_ADDR_W];
      write_out       = g_wr;
      read_out        = g_rd && !g_wr;
      write_value_out = m_write_value_in[gi*BUS_DATA_W +: BUS_DATA_W];
      if (g_wr)
        write_mask_out = m_write_mask_in[gi*BUS_MASK_W +: BUS_MASK_W];
    end
    if (done) begin
      m_ready_out[gi] = 1'b1;
      m_fault_out[gi] = fault_in || wd_fire;
      m_read_value_out[gi*BUS_DATA_W +: BUS_DATA_W] =
        wd_fire ? '0 : read_value_in;
    end
  end

  // Arbitration and transaction-lock state machine.
  always_comb begin
    ptr_next  = (gidx_q == PW'(N - 1)) ? '0 : gidx_q + PW'(1);
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    grant_d   = grant_q;
    wd_cnt_d  = wd_cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          state_d  = ARB_BUSY;
          grant_d  = pick_oh;
          gidx_d   = pick_idx;
          wd_cnt_d = '0;
        end
      end
      ARB_BUSY: begin
        if (done) begin
          state_d   = ARB_IDLE;
          ptr_d     = ptr_next;
          grant_d   = '0;
          timeout_d = wd_fire;
        end else if (!(g_rd || g_wr)) begin
          state_d = ARB_IDLE;
          ptr_d   = ptr_next;
          grant_d = '0;
        end else if (wd_cnt_q != TO_V) begin
          wd_cnt_d = wd_cnt_q + TW'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      grant_q   <= '0;
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      grant_q   <= grant_d;
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule
